spi_xfer_engine: RTL and testbench
==================================

SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 SHALL have parameter: W_FRAME, 8, bits per SPI frame.
REQ-002 SHALL have parameter: CLK_DIV, 4, clk cycles per sclk half-period; legal range 1..255.
REQ-003 SHALL have port: clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: tx_data  input  W_FRAME  frame to transmit on mosi, MSB first.
REQ-006 SHALL have port: tx_valid  input  1  tx_data valid, issued by the SPI register file.
REQ-007 SHALL have port: tx_ready  output  1  engine idle and able to accept a frame.
REQ-008 SHALL have port: rx_data  output  W_FRAME  last frame received on miso.
REQ-009 SHALL have port: rx_dv  output  1  one-cycle pulse when rx_data updates.
REQ-010 SHALL have port: busy  output  1  frame in progress (inverse of tx_ready).
REQ-011 SHALL have ports: sclk  output  1; mosi  output  1; miso  input  1; cs_n  output  1 (active-low chip select).

Function
REQ-012 SHALL use SPI mode 0: sclk idles low; miso sampled on sclk rise; mosi changes on sclk fall.
REQ-013 SHALL implement states IDLE, LEAD, SHIFT, TRAIL.
REQ-014 IDLE: tx_ready=1, busy=0, cs_n=1, sclk=0, mosi=0.
REQ-015 Accept SHALL occur on a posedge with tx_valid=1 and tx_ready=1: latch tx_data, enter LEAD.
REQ-016 LEAD: cs_n=0, mosi=tx_data[W_FRAME-1], sclk=0, lasting CLK_DIV cycles; then enter SHIFT.
REQ-017 SHIFT: sclk SHALL toggle every CLK_DIV cycles, giving W_FRAME full periods (2*W_FRAME*CLK_DIV cycles).
REQ-018 On the posedge where sclk goes 0->1, miso SHALL shift into the rx shift register LSB.
REQ-019 On each sclk 1->0 except the last, mosi SHALL advance to the next lower tx bit.
REQ-020 After the W_FRAME-th falling edge, SHALL enter TRAIL: cs_n=0, sclk=0 for CLK_DIV cycles.
REQ-021 TRAIL exit: return to IDLE; in that same cycle rx_data SHALL load and rx_dv SHALL be 1 for exactly one cycle.
REQ-022 Latency from cs_n falling to rx_dv SHALL be (2*W_FRAME+2)*CLK_DIV cycles (72 at defaults).
REQ-023 tx_valid while busy=1 SHALL be ignored; no queuing.
REQ-024 Back-to-back: accept in the rx_dv cycle is legal; cs_n SHALL stay high for exactly 1 cycle between frames.
REQ-025 rx_data SHALL hold its value between rx_dv pulses.
REQ-026 The divider counter SHALL be $clog2(CLK_DIV+1) bits wide and reload on each terminal count; no wrap glitch on sclk.

Reset
REQ-027 rst=1 at posedge SHALL force IDLE from any state, including mid-frame, with no rx_dv.
REQ-028 Reset values SHALL be: tx_ready=1, busy=0, cs_n=1, sclk=0, mosi=0, rx_dv=0, rx_data=0, shift registers and counters=0.
REQ-029 A frame aborted by reset SHALL not affect the next frame's data.

Configuration
REQ-030 Macro SPI_XFER_LOOPBACK_EN: when defined, miso SHALL be ignored and the rx shift register SHALL sample the internal mosi, so rx_data equals the transmitted frame.
REQ-031 Without SPI_XFER_LOOPBACK_EN, the rx shift register SHALL sample the miso port; timing is identical in both builds.

Verification
REQ-032 Reset check: hold rst 2 cycles -> tx_ready=1, cs_n=1, sclk=0, mosi=0, rx_dv=0, rx_data=0x00.
REQ-033 Single frame at defaults: tx 0xA5, slave model returns 0x3C -> mosi 1,0,1,0,0,1,0,1 at 8 sclk rises; rx_data=0x3C; rx_dv 72 cycles after cs_n falls.
REQ-034 Busy drop: 0xFF offered with tx_valid held during a frame -> not accepted until the rx_dv cycle; exactly one extra frame sent.
REQ-035 Back-to-back: 0x01 then 0x80 -> cs_n high exactly 1 cycle between frames; mosi sequences correct.
REQ-036 Reset mid-frame after the 4th sclk rise -> cs_n=1 and sclk=0 next cycle, no rx_dv; next frame 0x55 with miso 0xAA gives rx_data=0xAA.
REQ-037 Loopback build, CLK_DIV=1: tx 0x5A -> rx_data=0x5A, rx_dv 18 cycles after cs_n falls.

Source files
------------

// File: rtl/spi_xfer_engine.sv
// SPI mode-0 master that shifts one frame per transaction.
//
// Handshake: a frame is accepted on a clock edge with tx_valid=1 and tx_ready=1.
// Each frame runs LEAD (cs_n low, sclk low, CLK_DIV cycles), then SHIFT
// (W_FRAME sclk periods), then TRAIL (cs_n low, sclk low, CLK_DIV cycles).
// On TRAIL exit the engine returns to idle, loads rx_data and pulses rx_dv.
//
// Ports:
//   clk       system clock, all logic on its rising edge
//   rst       synchronous active-high reset
//   tx_data   frame to send, MSB first     tx_valid  tx_data is valid
//   tx_ready  idle, can accept a frame     busy      frame in progress
//   rx_data   last received frame          rx_dv     one-cycle update strobe
//   sclk/mosi/cs_n  SPI outputs            miso      SPI input
//
// Build option: define SPI_XFER_LOOPBACK_EN to ignore miso and sample the
// engine's own mosi, so rx_data equals the transmitted frame.

module spi_xfer_engine #(
    parameter int unsigned W_FRAME = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_FRAME-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [W_FRAME-1:0] rx_data,
    output logic               rx_dv,
    output logic               busy,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               cs_n
);

    localparam int unsigned CntW = $clog2(CLK_DIV + 1);
    localparam int unsigned BitW = $clog2(W_FRAME + 1);
    localparam logic [CntW-1:0] CntReload = CntW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] LastBit   = BitW'(W_FRAME - 1);

    typedef enum logic [1:0] {StIdle, StLead, StShift, StTrail} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic [W_FRAME-1:0] tx_sr_q, tx_sr_d;
    logic [W_FRAME-1:0] rx_sr_q, rx_sr_d;
    logic [W_FRAME-1:0] rx_data_q, rx_data_d;
    logic               rx_dv_q, rx_dv_d;
    logic               idle;
    logic               tc;
    logic               rx_in;

    assign idle     = (state_q == StIdle);
    assign tx_ready = idle;
    assign busy     = ~idle;
    assign cs_n     = idle;
    assign sclk     = sclk_q;
    assign mosi     = ~idle & tx_sr_q[W_FRAME-1];
    assign rx_data  = rx_data_q;
    assign rx_dv    = rx_dv_q;

`ifdef SPI_XFER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_in       = mosi;
`else
    assign rx_in = miso;
`endif

    // Down-counter: terminal count at zero, reloaded so every phase is CLK_DIV cycles.
    assign tc = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        rx_dv_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d = StLead;
                    cnt_d   = CntReload;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                end
            end
            StLead: begin
                if (tc) begin
                    state_d = StShift;
                    cnt_d   = CntReload;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StShift: begin
                if (tc) begin
                    cnt_d  = CntReload;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising sclk: capture the slave bit.
                        rx_sr_d = {rx_sr_q[W_FRAME-2:0], rx_in};
                    end else if (bit_q == LastBit) begin
                        // Last falling sclk: keep mosi, close the frame.
                        state_d = StTrail;
                    end else begin
                        tx_sr_d = tx_sr_q << 1;
                        bit_d   = bit_q + BitW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StTrail: begin
                if (tc) begin
                    state_d   = StIdle;
                    rx_data_d = rx_sr_q;
                    rx_dv_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            rx_dv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            rx_dv_q   <= rx_dv_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Self-checking bench for spi_xfer_engine at default parameters.
// A timing model (cycles since cs_n fell) predicts every output each cycle;
// directed tests pin the model with hand-computed literals.

module tb_spi_xfer_engine;

    localparam int W         = 8;
    localparam int D         = 4;
    localparam int SHIFT_END = D + 2 * W * D;  // first TRAIL cycle after cs_n fall
    localparam int DONE      = SHIFT_END + D;  // rx_dv cycle
`ifdef SPI_XFER_LOOPBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic         clk, rst, tx_valid, tx_ready, rx_dv, busy, sclk, mosi, miso, cs_n;
    logic [W-1:0] tx_data, rx_data, slave_word;

    int total = 0;
    int bad   = 0;

    spi_xfer_engine #(
        .W_FRAME(W),
        .CLK_DIV(D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_dv   (rx_dv),
        .busy    (busy),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Mode-0 slave: presents MSB before the first rise, next bit after each fall.
    int   s_falls = 0;
    logic s_prev  = 1'b0;
    initial forever begin
        @(negedge clk);
        if (cs_n) s_falls = 0;
        else if (s_prev && !sclk) s_falls++;
        s_prev = sclk;
    end
    always_comb begin
        miso = 1'b0;
        if (!cs_n) miso = slave_word[W-1-((s_falls > W-1) ? W-1 : s_falls)];
    end

    // Bus monitor: mosi at sclk rises, frame count, rx_dv count, cs_n-high gap.
    logic [W-1:0] rise_bits = '0;
    int           n_frames = 0, n_dv = 0, cs_run = 0, last_gap = 0;
    logic         m_sclk = 1'b0, m_cs = 1'b1;
    initial forever begin
        @(negedge clk);
        if (!cs_n && m_cs) begin
            n_frames++;
            last_gap  = cs_run;
            rise_bits = '0;
        end else if (sclk && !m_sclk) begin
            rise_bits = {rise_bits[W-2:0], mosi};
        end
        if (rx_dv) n_dv++;
        cs_run = cs_n ? cs_run + 1 : 0;
        m_sclk = sclk;
        m_cs   = cs_n;
    end

    // Reference model: mt = cycles since cs_n fell (-1 idle).
    int           mt = -1;
    bit           model_ok = 1'b0;
    logic [W-1:0] p_tx = '0, p_rx = '0, e_rx = '0;
    logic [13:0]  m_got, m_want;
    logic         act, e_sclk, e_mosi, mmask;
    int           idx;
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            act    = (mt >= 0 && mt < DONE);
            e_sclk = 1'b0;
            e_mosi = 1'b0;
            mmask  = 1'b1;
            if (act) begin
                if (mt >= D && mt < SHIFT_END) e_sclk = (((mt - D) / D) % 2) == 1;
                if (mt < SHIFT_END) begin
                    idx    = (mt < D) ? 0 : (mt - D) / (2 * D);
                    e_mosi = p_tx[W-1-idx];
                end else begin
                    mmask = 1'b0;  // mosi is don't-care in TRAIL
                end
            end
            m_want = {~act, act, ~act, e_sclk, e_mosi, (mt == DONE), e_rx};
            m_got  = {tx_ready, busy, cs_n, sclk, mosi & mmask, rx_dv, rx_data};
            chk("cycle{rdy,busy,csn,sclk,mosi,dv,rx}", 32'(m_got), 32'(m_want));
        end
        if (rst) begin
            mt       = -1;
            e_rx     = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if ((mt < 0 || mt == DONE) && tx_valid) begin
                mt   = 0;
                p_tx = tx_data;
                p_rx = LOOP ? tx_data : slave_word;
            end else if (mt >= 0 && mt < DONE) begin
                mt++;
                if (mt == DONE) e_rx = p_rx;
            end else begin
                mt = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a frame while idle; returns in the first cs_n-low cycle.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] sw);
        bit ok = 1'b0;
        tx_data    = d;
        slave_word = sw;
        tx_valid   = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            ok = !cs_n;
        end
        tx_valid = 1'b0;
        chk("accepted", 32'(ok), 32'd1);
    endtask

    // Returns in the rx_dv cycle; n = cycles waited.
    task automatic wait_dv(output int n);
        bit seen = 1'b0;
        n = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            n++;
            seen = rx_dv;
        end
        chk("rx_dv_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int n, f0, d0, rises, k;
        logic ps;
        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = '0;
        slave_word = '0;

        // Reset state
        tick();
        tick();
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rx_dv", 32'(rx_dv), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        repeat (2) tick();

        // Single frame 0xA5, slave returns 0x3C
        send(8'hA5, 8'h3C);
        wait_dv(n);
        chk("single_latency", 32'(n), 32'd72);
        chk("single_mosi_bits", 32'(rise_bits), 32'hA5);
        chk("single_rx_data", 32'(rx_data), LOOP ? 32'hA5 : 32'h3C);
        tick();
        chk("single_dv_one_cycle", 32'(rx_dv), 32'd0);
        chk("single_rx_hold", 32'(rx_data), LOOP ? 32'hA5 : 32'h3C);
        repeat (3) tick();

        // Busy drop: 0xFF held during a frame, taken only in the rx_dv cycle
        f0 = n_frames;
        send(8'h12, 8'h34);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        wait_dv(n);
        chk("busy_first_mosi", 32'(rise_bits), 32'h12);
        chk("busy_first_rx", 32'(rx_data), LOOP ? 32'h12 : 32'h34);
        tick();
        chk("busy_accept_at_dv", 32'(cs_n), 32'd0);
        tx_valid = 1'b0;
        wait_dv(n);
        chk("busy_second_mosi", 32'(rise_bits), 32'hFF);
        chk("busy_second_rx", 32'(rx_data), LOOP ? 32'hFF : 32'h34);
        repeat (3) tick();
        chk("busy_frame_count", 32'(n_frames - f0), 32'd2);

        // Back-to-back 0x01 then 0x80
        send(8'h01, 8'hC3);
        wait_dv(n);
        chk("b2b_first_mosi", 32'(rise_bits), 32'h01);
        send(8'h80, 8'h69);
        wait_dv(n);
        chk("b2b_second_mosi", 32'(rise_bits), 32'h80);
        chk("b2b_second_rx", 32'(rx_data), LOOP ? 32'h80 : 32'h69);
        chk("b2b_cs_gap", 32'(last_gap), 32'd1);
        repeat (2) tick();

        // Reset after the 4th sclk rise
        send(8'hE7, 8'h5A);
        rises = 0;
        ps    = 1'b0;
        for (int i = 0; i < 200 && rises < 4; i++) begin
            tick();
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        chk("abort_rises", 32'(rises), 32'd4);
        d0  = n_dv;
        rst = 1'b1;
        tick();
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("abort_no_dv", 32'(n_dv - d0), 32'd0);
        chk("abort_rx_cleared", 32'(rx_data), 32'h00);
        send(8'h55, 8'hAA);
        wait_dv(n);
        chk("abort_next_rx", 32'(rx_data), LOOP ? 32'h55 : 32'hAA);
        chk("abort_next_mosi", 32'(rise_bits), 32'h55);

        // Random frames with busy-time noise, gaps and occasional aborts
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(W'($urandom), W'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, 70);
                for (int j = 0; j < k; j++) begin
                    tx_valid = 1'($urandom);
                    tx_data  = W'($urandom);
                    tick();
                end
                tx_valid = 1'b0;
                rst      = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                for (int j = 0; j < 40; j++) begin
                    tx_valid = 1'($urandom);
                    tx_data  = W'($urandom);
                    tick();
                end
                tx_valid = 1'b0;
                wait_dv(n);
            end
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
